// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues single-outstanding reads to instruction
// memory and queues returned words in a small prefetch buffer.
// Ports:
//   clk, rst (sync, active-low)
//   mem_req/mem_addr/mem_ack/mem_rdata : instruction memory read port
//   inst_valid/inst/inst_pc/inst_ready : head of prefetch buffer to CPU
//   redirect/redirect_pc               : branch/jump strobe and target
module fetch_unit #(
    parameter int ADDR_W = 12,
    parameter int INST_W = 19,
    parameter int DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pend_addr;
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     count;

    logic [INST_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];

    logic req_int;
    logic valid_int;
    logic push;
    logic pop;

    // Request is a function of registered state; rst gates it so the
    // outputs are quiet during the reset cycle itself.
    assign req_int   = (state == DRAIN) ||
                       ((state == FETCH) && (count < CW'(DEPTH)));
    assign valid_int = (count != '0) && (state != IDLE);

    assign mem_req    = rst && req_int;
    assign mem_addr   = (state == DRAIN) ? pend_addr : fetch_pc;
    assign inst_valid = rst && valid_int;
    assign inst       = data_q[rptr];
    assign inst_pc    = pc_q[rptr];

    // Redirect wins over both buffer operations.
    assign push = rst && (state == FETCH) && req_int && mem_ack && !redirect;
    assign pop  = inst_valid && inst_ready && !redirect;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            pend_addr <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
        end else begin
            unique case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    // Redirect with an unacked request: hold the old
                    // address until memory answers, then discard it.
                    if (redirect && req_int && !mem_ack) begin
                        state     <= DRAIN;
                        pend_addr <= fetch_pc;
                    end
                end
                DRAIN: begin
                    if (mem_ack) state <= FETCH;
                end
                default: state <= IDLE;
            endcase

            if (redirect) begin
                fetch_pc <= redirect_pc;
                wptr     <= '0;
                rptr     <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + 1'b1;
                    wptr     <= wptr + 1'b1;
                end
                if (pop) rptr <= rptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (!push && pop) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wptr] <= mem_rdata;
            pc_q[wptr]   <= mem_addr;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with programmable
// latency, scoreboard of expected {pc, inst} pops, vector table.
module tb_fetch_unit;

    localparam int AW = 12;
    localparam int IW = 19;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic          mem_ack_m = 1'b0;
    logic          stray_ack = 1'b0;
    logic [IW-1:0] mem_rdata = '0;
    logic          inst_valid;
    logic [IW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          inst_ready = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;

    assign mem_ack = mem_ack_m | stray_ack;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] data;
    } exp_t;

    typedef struct {
        logic [AW-1:0] target;
        int            lat;
        int            n;
        logic [AW-1:0] last_pc;
    } vec_t;

    exp_t          q[$];
    exp_t          e;
    int            tests = 0;
    int            fails = 0;
    int            lat = 1;
    int            cnt = 0;
    int            ncomp = 0;
    logic          prev_pend = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [AW-1:0] last_pc = '0;

    function automatic logic [IW-1:0] dat(input logic [AW-1:0] a);
        return {{(IW-AW){1'b0}}, a} + 19'h100;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] pc0, input int n);
        logic [AW-1:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = pc0 + AW'(i);
            q.push_back('{pc, dat(pc)});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            #2;
            n++;
        end
        chk({name, "_left"}, q.size(), 0);
        tick();
        inst_ready = 1'b0;
    endtask

    // Memory: acks after lat cycles of a held request; reset drops state.
    always @(negedge clk) begin
        if (!rst) begin
            mem_ack_m = 1'b0;
            cnt = 0;
        end else begin
            if (mem_ack_m) begin
                mem_ack_m = 1'b0;
                cnt = 0;
            end
            if (mem_req) begin
                cnt++;
                if (cnt >= lat) begin
                    mem_ack_m = 1'b1;
                    mem_rdata = dat(mem_addr);
                end
            end
        end
    end

    // Monitor: request stability and scoreboard pops.
    always @(negedge clk) begin
        #2;
        if (rst && prev_pend) begin
            tests++;
            if (!(mem_req && mem_addr == prev_addr)) begin
                fails++;
                $display("FAIL req_hold: req %0b addr %0h, expected 1 addr %0h",
                         mem_req, mem_addr, prev_addr);
            end
        end
        prev_pend = rst && mem_req && !mem_ack;
        prev_addr = mem_addr;
        if (rst && mem_req && mem_ack) ncomp++;
        if (rst && inst_valid && inst_ready && !redirect) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got pc %0h, expected no pop",
                         inst_pc);
            end else begin
                e = q.pop_front();
                chk("pop_pc", inst_pc, e.pc);
                chk("pop_inst", inst, e.data);
                last_pc = inst_pc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[5];
        int   n;
        vt[0] = '{12'h040, 1, 6, 12'h045};
        vt[1] = '{12'h7ff, 2, 5, 12'h803};
        vt[2] = '{12'hffe, 1, 4, 12'h001};
        vt[3] = '{12'h123, 3, 4, 12'h126};
        vt[4] = '{12'hffd, 2, 6, 12'h002};

        // Reset then stream
        repeat (3) tick();
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_inst_valid", inst_valid, 0);
        push_exp(12'h000, 8);
        inst_ready = 1'b1;
        tick();
        rst = 1'b1;
        #2;
        chk("idle_req", mem_req, 0);
        chk("idle_valid", inst_valid, 0);
        tick();
        #2;
        chk("first_req", mem_req, 1);
        chk("first_addr", mem_addr, 0);
        n = 0;
        while (!inst_valid && n < 10) begin
            tick();
            #2;
            n++;
        end
        chk("stream_start", inst_valid, 1);
        n = 0;
        while (q.size() != 0 && n < 30) begin
            tick();
            #2;
            n++;
        end
        chk("stream_nogap", n, 7);
        tick();
        inst_ready = 1'b0;

        // Backpressure after a fresh reset
        rst = 1'b0;
        q.delete();
        tick();
        tick();
        rst = 1'b1;
        ncomp = 0;
        push_exp(12'h000, 8);
        repeat (12) tick();
        #2;
        chk("bp_req_low", mem_req, 0);
        chk("bp_words", ncomp, 4);
        chk("bp_head_pc", inst_pc, 0);
        chk("bp_head_inst", inst, 19'h100);
        repeat (3) tick();
        #2;
        chk("bp_inst_held", inst, 19'h100);
        tick();
        inst_ready = 1'b1;
        wait_empty("bp", 40);

        // Redirect vectors
        for (int i = 0; i < 5; i++) begin
            lat = vt[i].lat;
            repeat (3) tick();
            redirect = 1'b1;
            redirect_pc = vt[i].target;
            q.delete();
            push_exp(vt[i].target, vt[i].n);
            inst_ready = 1'b1;
            tick();
            redirect = 1'b0;
            wait_empty("vec", 60);
            chk("vec_last_pc", last_pc, vt[i].last_pc);
        end

        // Redirect while a request is pending
        lat = 1;
        repeat (12) tick();
        #2;
        chk("pend_pre_full", mem_req, 0);
        tick();
        lat = 3;
        redirect = 1'b1;
        redirect_pc = 12'h005;
        q.delete();
        tick();
        chk("pend_req5", mem_req, 1);
        chk("pend_addr5", mem_addr, 12'h005);
        redirect_pc = 12'h200;
        q.delete();
        push_exp(12'h200, 4);
        inst_ready = 1'b1;
        tick();
        redirect = 1'b0;
        #2;
        chk("drain_addr", mem_addr, 12'h005);
        tick();
        #2;
        chk("drain_ack_addr", mem_addr, 12'h005);
        chk("drain_ack", mem_ack, 1);
        tick();
        #2;
        chk("after_drain_addr", mem_addr, 12'h200);
        chk("after_drain_req", mem_req, 1);
        wait_empty("pend", 60);
        chk("pend_last_pc", last_pc, 12'h203);

        // Redirect coinciding with a completion
        lat = 1;
        redirect = 1'b1;
        redirect_pc = 12'h010;
        q.delete();
        push_exp(12'h010, 16);
        inst_ready = 1'b1;
        tick();
        redirect = 1'b0;
        repeat (4) tick();
        chk("ack_cycle", mem_req && mem_ack, 1);
        redirect = 1'b1;
        redirect_pc = 12'h300;
        q.delete();
        push_exp(12'h300, 4);
        tick();
        redirect = 1'b0;
        #2;
        chk("ackredir_valid", inst_valid, 0);
        chk("ackredir_addr", mem_addr, 12'h300);
        wait_empty("ackredir", 40);
        chk("ackredir_last", last_pc, 12'h303);

        // Full buffer, ready and redirect together
        repeat (12) tick();
        #2;
        chk("full_valid", inst_valid, 1);
        tick();
        inst_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 12'h400;
        q.delete();
        push_exp(12'h400, 4);
        tick();
        redirect = 1'b0;
        #2;
        chk("fullredir_valid", inst_valid, 0);
        chk("fullredir_addr", mem_addr, 12'h400);
        chk("fullredir_req", mem_req, 1);
        wait_empty("fullredir", 40);
        chk("fullredir_last", last_pc, 12'h403);

        // Reset in the middle of a drain, then a stray ack
        repeat (12) tick();
        tick();
        lat = 5;
        redirect = 1'b1;
        redirect_pc = 12'h010;
        q.delete();
        tick();
        redirect_pc = 12'h020;
        tick();
        redirect = 1'b0;
        #2;
        chk("rd_hold", mem_addr, 12'h010);
        tick();
        rst = 1'b0;
        q.delete();
        #2;
        chk("rd_rst_req", mem_req, 0);
        tick();
        rst = 1'b1;
        stray_ack = 1'b1;
        lat = 1;
        push_exp(12'h000, 4);
        inst_ready = 1'b1;
        #2;
        chk("rd_idle_req", mem_req, 0);
        tick();
        stray_ack = 1'b0;
        #2;
        chk("rd_first_req", mem_req, 1);
        chk("rd_first_addr", mem_addr, 12'h000);
        wait_empty("rd", 40);
        chk("rd_last", last_pc, 12'h003);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
